// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed per-channel spike rate counter with valid/ready output
// Optional ch0 inter-spike interval meter enabled by macro ISI_MEAS_EN.
module spike_rate_decoder #(
  parameter int N_CH   = 3,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  input  logic [N_CH-1:0]         spike_in,
  output logic [N_CH*CNT_W-1:0]   rate_out,
  output logic                    rate_valid,
  input  logic                    rate_ready,
  output logic                    overrun,
  output logic [CNT_W-1:0]        isi_out,
  output logic                    isi_valid
);

  localparam int WC_W = $clog2(WINDOW);
  localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

  logic [N_CH-1:0]       spike_prev;
  logic [N_CH-1:0]       spike_evt;
  logic [WC_W-1:0]       win_cnt;
  logic [N_CH*CNT_W-1:0] acc;
  logic [N_CH*CNT_W-1:0] acc_inc;
  logic                  win_close;
  logic                  accept;
  out_state_t            state;
  out_state_t            state_next;

  assign spike_evt = spike_in & ~spike_prev;
  assign win_close = en && !clear && (win_cnt == WIN_LAST);
  assign accept    = rate_valid && rate_ready;

  // Accumulators with this cycle's events folded in; also the value captured at close.
  always_comb begin
    acc_inc = acc;
    for (int k = 0; k < N_CH; k++) begin
      if (spike_evt[k] && (acc[k*CNT_W +: CNT_W] != CNT_MAX))
        acc_inc[k*CNT_W +: CNT_W] = acc[k*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_prev <= '0;
      win_cnt    <= '0;
      acc        <= '0;
    end else begin
      spike_prev <= spike_in;
      if (clear) begin
        win_cnt <= '0;
        acc     <= '0;
      end else if (en) begin
        if (win_cnt == WIN_LAST) begin
          win_cnt <= '0;
          acc     <= '0;
        end else begin
          win_cnt <= win_cnt + WC_W'(1);
          acc     <= acc_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= EMPTY;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (win_close) state_next = FULL;
      FULL:    if (accept && !win_close) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    rate_valid = (state == FULL);
  end

  // Overwriting an unaccepted window flags overrun; a simultaneous accept consumed it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_out <= '0;
      overrun  <= 1'b0;
    end else if (win_close) begin
      rate_out <= acc_inc;
      overrun  <= rate_valid && !rate_ready;
    end else if (accept) begin
      overrun  <= 1'b0;
    end
  end

`ifdef ISI_MEAS_EN
  logic [CNT_W-1:0] isi_cnt;
  logic             isi_armed;

  // Counter reloads to 1 on an event so the next event sees the true cycle distance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isi_cnt   <= '0;
      isi_armed <= 1'b0;
      isi_out   <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (spike_evt[0]) begin
        isi_armed <= 1'b1;
        isi_cnt   <= CNT_W'(1);
        if (isi_armed) begin
          isi_out   <= isi_cnt;
          isi_valid <= 1'b1;
        end
      end else if (isi_cnt != CNT_MAX) begin
        isi_cnt <= isi_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign isi_out   = '0;
  assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - directed bench with cycle model for spike_rate_decoder
module tb_spike_rate_decoder;

  localparam int WIN  = 16;
  localparam int MAXC = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clear;
  logic        rate_ready;
  logic [2:0]  spike_in;
  logic [23:0] rate_out;
  logic        rate_valid;
  logic        overrun;
  logic [7:0]  isi_out;
  logic        isi_valid;

  logic        sat_en;
  logic [2:0]  sat_spk;
  logic [11:0] sat_rate;
  logic        sat_valid;
  logic        sat_ovr;
  logic [3:0]  sat_isi;
  logic        sat_isi_v;

  int n_chk  = 0;
  int n_fail = 0;
  bit check_on = 1'b0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.N_CH(3), .WINDOW(WIN), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .spike_in(spike_in),
    .rate_out(rate_out), .rate_valid(rate_valid), .rate_ready(rate_ready),
    .overrun(overrun), .isi_out(isi_out), .isi_valid(isi_valid)
  );

  spike_rate_decoder #(.N_CH(3), .WINDOW(64), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en(sat_en), .clear(1'b0), .spike_in(sat_spk),
    .rate_out(sat_rate), .rate_valid(sat_valid), .rate_ready(1'b1),
    .overrun(sat_ovr), .isi_out(sat_isi), .isi_valid(sat_isi_v)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: integer counts per window, a one-deep output slot, interval by timestamps.
  int          m_cnt [3];
  int          m_en_n;
  logic [23:0] m_rate;
  bit          m_valid, m_ovr;
  logic [2:0]  m_prev;
  int          m_cyc = 0;
  int          m_last;
  bit          m_armed;
  logic [7:0]  m_isi;
  bit          m_isi_v;

  always @(posedge clk or posedge rst) begin : model
    logic [2:0] ev;
    bit         acc_m;
    bit         cls;
    if (rst) begin
      m_prev = '0; m_en_n = 0; m_rate = '0; m_valid = 0; m_ovr = 0;
      m_armed = 0; m_isi = '0; m_isi_v = 0; m_last = 0;
      for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    end else begin
      ev    = spike_in & ~m_prev;
      acc_m = m_valid && rate_ready;
      cls   = 0;
      if (clear) begin
        m_en_n = 0;
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
      end else if (en) begin
        for (int k = 0; k < 3; k++)
          if (ev[k]) m_cnt[k] = (m_cnt[k] < MAXC) ? m_cnt[k] + 1 : MAXC;
        m_en_n++;
        if (m_en_n == WIN) begin
          cls = 1;
          for (int k = 0; k < 3; k++) begin
            m_rate[k*8 +: 8] = 8'(m_cnt[k]);
            m_cnt[k] = 0;
          end
          m_en_n = 0;
        end
      end
      if (cls) begin
        m_ovr   = m_valid && !acc_m;
        m_valid = 1;
      end else if (acc_m) begin
        m_valid = 0;
        m_ovr   = 0;
      end
      m_isi_v = 0;
      if (ev[0]) begin
        if (m_armed) begin
          m_isi   = 8'(((m_cyc - m_last) > MAXC) ? MAXC : (m_cyc - m_last));
          m_isi_v = 1;
        end
        m_last  = m_cyc;
        m_armed = 1;
      end
      m_prev = spike_in;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (check_on && !rst) begin
      chk("cyc_rate_valid", rate_valid, m_valid);
      chk("cyc_overrun", overrun, m_ovr);
      chk("cyc_rate_out", rate_out, m_rate);
`ifdef ISI_MEAS_EN
      chk("cyc_isi_valid", isi_valid, m_isi_v);
      chk("cyc_isi_out", isi_out, m_isi);
`else
      chk("cyc_isi_valid", isi_valid, 1'b0);
      chk("cyc_isi_out", isi_out, 8'd0);
`endif
    end
  end

  task automatic step(input logic e, input logic [2:0] s, input logic c, input logic r);
    en = e; spike_in = s; clear = c; rate_ready = r;
    @(posedge clk); #1;
  endtask

  // One full window of WIN enabled cycles with np pulses on mask; ready may differ on the closing cycle.
  task automatic window(input logic [2:0] mask, input int np, input logic r_body, input logic r_last);
    for (int i = 0; i < np; i++) begin
      step(1'b1, mask, 1'b0, r_body);
      step(1'b1, 3'b000, 1'b0, r_body);
    end
    for (int i = 0; i < WIN - 2*np - 1; i++) step(1'b1, 3'b000, 1'b0, r_body);
    step(1'b1, 3'b000, 1'b0, r_last);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; spike_in = '0; rate_ready = 1'b0;
    sat_en = 1'b0; sat_spk = '0;
    @(posedge clk); #1;
    chk("reset_valid", rate_valid, 1'b0);
    chk("reset_rate", rate_out, 24'h0);
    chk("reset_overrun", overrun, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_on = 1'b1;

    // Basic window: ch0 five pulses, ch1 held high, ch2 idle
    for (int i = 0; i < WIN; i++)
      step(1'b1, {1'b0, 1'b1, ((i % 2 == 1) && (i < 10))}, 1'b0, 1'b1);
    chk("basic_valid", rate_valid, 1'b1);
    chk("basic_rate", rate_out, 24'h000105);
    chk("model_basic_rate", m_rate, 24'h000105);
    step(1'b0, 3'b010, 1'b0, 1'b1);
    chk("basic_accepted", rate_valid, 1'b0);

    // Backpressure across two closes
    window(3'b001, 1, 1'b0, 1'b0);
    window(3'b101, 3, 1'b0, 1'b0);
    chk("bp_overrun", overrun, 1'b1);
    chk("bp_rate", rate_out, 24'h030003);
    step(1'b0, 3'b000, 1'b0, 1'b1);
    chk("bp_drain_valid", rate_valid, 1'b0);
    chk("bp_drain_overrun", overrun, 1'b0);

    // Close coinciding with accept after an overrun
    window(3'b001, 1, 1'b0, 1'b0);
    window(3'b010, 2, 1'b0, 1'b0);
    chk("coinc_pre_overrun", overrun, 1'b1);
    window(3'b110, 4, 1'b0, 1'b1);
    chk("coinc_valid", rate_valid, 1'b1);
    chk("coinc_overrun", overrun, 1'b0);
    chk("coinc_rate", rate_out, 24'h040400);

    // Asynchronous reset mid-window
    for (int i = 0; i < 7; i++) step(1'b1, 3'b000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", rate_valid, 1'b0);
    chk("async_rst_rate", rate_out, 24'h0);
    chk("async_rst_overrun", overrun, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // en=0 gap with ignored pulses delays the close
    step(1'b1, 3'b001, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, (i % 2 == 0) ? 3'b001 : 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 3'b000, 1'b0, 1'b1);
    chk("gap_not_closed", rate_valid, 1'b0);
    step(1'b1, 3'b000, 1'b0, 1'b1);
    chk("gap_closed", rate_valid, 1'b1);
    chk("gap_rate", rate_out, 24'h000001);

    // clear at win_cnt=9 drops pre-clear spikes and restarts the window
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'b100, 1'b0, 1'b1);
      step(1'b1, 3'b000, 1'b0, 1'b1);
    end
    step(1'b1, 3'b000, 1'b0, 1'b1);
    step(1'b1, 3'b000, 1'b1, 1'b1);
    step(1'b1, 3'b001, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b1, 3'b000, 1'b0, 1'b1);
    chk("clr_not_closed", rate_valid, 1'b0);
    step(1'b1, 3'b000, 1'b0, 1'b1);
    chk("clr_closed", rate_valid, 1'b1);
    chk("clr_rate", rate_out, 24'h000001);

    // ch0 events seven cycles apart
    step(1'b0, 3'b000, 1'b0, 1'b1);
    step(1'b0, 3'b001, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 3'b000, 1'b0, 1'b1);
    step(1'b0, 3'b001, 1'b0, 1'b1);
`ifdef ISI_MEAS_EN
    chk("isi_strobe", isi_valid, 1'b1);
    chk("isi_value", isi_out, 8'd7);
`else
    chk("isi_strobe_off", isi_valid, 1'b0);
    chk("isi_value_off", isi_out, 8'd0);
`endif
    step(1'b0, 3'b000, 1'b0, 1'b1);
    chk("isi_strobe_end", isi_valid, 1'b0);

    // Saturation: 32 edges into a 4-bit counter over a 64-cycle window
    sat_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      sat_spk = {2'b00, (i % 2 == 0)};
      step(1'b0, 3'b000, 1'b0, 1'b1);
    end
    sat_en = 1'b0;
    chk("sat_valid", sat_valid, 1'b1);
    chk("sat_ch0", sat_rate[3:0], 4'd15);
    chk("sat_ch12", sat_rate[11:4], 8'd0);

    check_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
